// File: rtl/serial_adder_n.sv
// Bit-serial adder: one full-adder cell, WIDTH clocks per operation, registered sum/cout/ovf.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             sub_eff;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_cat;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Single full-adder cell on the operand LSBs and the running carry.
    assign bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_c   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign res_cat = {bit_s, res_q};

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    // Subtraction is a + ~b + 1, so the forced carry replaces cin.
                    b_d     = b ^ {WIDTH{sub_eff}};
                    carry_d = sub_eff | cin;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                res_d   = res_cat[WIDTH-1:1];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = res_cat;
                    cout_d  = bit_c;
                    // carry_q is the carry into the MSB at this point.
                    ovf_d   = carry_q ^ bit_c;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n: an arithmetic reference model predicts results and
// busy/done timing; a monitor compares every cycle on the falling edge.
module tb_serial_adder_n;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_last;
    int   age = -1;   // cycles since the accepted start edge, -1 when idle
    int   checks = 0;
    int   failures = 0;

    serial_adder_n #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: accepts start only when idle, computes the result with plain arithmetic.
    function automatic exp_t model_result(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic ms);
        exp_t         r;
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   full;
        bb     = ms ? ~mb : mb;
        ci     = ms ? 1'b1 : mc;
        full   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
        r.s    = full[W-1:0];
        r.c    = full[W];
        r.v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return r;
    endfunction

    initial begin
        logic sm;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                age = -1;
                sb_q.delete();
            end else if (age < 0) begin
                if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
                    sm = sub;
`else
                    sm = 1'b0;
`endif
                    sb_q.push_back(model_result(a, b, cin, sm));
                    age = 0;
                end
            end else if (age == W) begin
                age = -1;
            end else begin
                age++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT signals done.
    initial begin
        exp_last.s = '0;
        exp_last.c = 1'b0;
        exp_last.v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_last.s = '0;
                exp_last.c = 1'b0;
                exp_last.v = 1'b0;
            end
            check("busy", busy, (age >= 0 && age < W));
            check("done", done, (age == W));
            if (done) begin
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) exp_last = sb_q.pop_front();
            end
            check("sum", sum, exp_last.s);
            check("cout", cout, exp_last.c);
            check("ovf", ovf, exp_last.v);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; operands are scrambled afterwards to prove they are not re-read.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic ts);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        sub   = ts;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        cycles(2);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, ovf, busy, done}, 0);
        rst_n = 1'b1;
        cycles(1);

        // Basic latency and carry-in.
        issue(8'h00, 8'h00, 1'b1, 1'b0);
        cycles(W + 1);
        // Carry-out and signed overflow boundaries.
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        cycles(W + 1);
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        cycles(W + 1);
        issue(8'h80, 8'h80, 1'b0, 1'b0);
        cycles(W + 1);

        // Start during RUN (3rd RUN cycle) must be ignored.
        issue(8'h10, 8'h20, 1'b0, 1'b0);
        cycles(2);
        issue(8'hAA, 8'h55, 1'b0, 1'b0);
        cycles(W - 2);

        // Reset in the 4th RUN cycle aborts the operation immediately.
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        cycles(3);
        rst_n = 1'b0;
        #1;
        check("abort_sum", sum, 0);
        check("abort_flags", {cout, ovf, busy, done}, 0);
        cycles(1);
        rst_n = 1'b1;
        cycles(1);
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        cycles(W + 1);

`ifdef SERIAL_ADDER_SUB_EN
        issue(8'h05, 8'h07, 1'b1, 1'b1);
        cycles(W + 1);
        issue(8'h80, 8'h01, 1'b0, 1'b1);
        cycles(W + 1);
        issue(8'h07, 8'h07, 1'b0, 1'b1);
        cycles(W + 1);
`endif

        // Start held high relaunches on every return to IDLE.
        a     = 8'h3C;
        b     = 8'hC5;
        cin   = 1'b1;
        sub   = 1'b0;
        start = 1'b1;
        cycles(3 * (W + 2));
        start = 1'b0;
        cycles(W + 2);

        // Randomized traffic: start asserted at random, operands change every cycle.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            cycles(1);
        end
        start = 1'b0;
        cycles(W + 3);
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
